// File: rtl/alu_issue_decoder_if.sv
// Handshake bundles around the ALU issue stage.
// instr_if: upstream instr/pc; issue_if: decoded ALU-side bundle.
interface instr_if;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] pc;

  modport master (
    output instr_valid, instr, pc,
    input  instr_ready
  );
  modport slave (
    input  instr_valid, instr, pc,
    output instr_ready
  );
endinterface

interface issue_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  ALU_Control;
  logic [31:0] oprand_1;
  logic [31:0] oprand_2;
  logic [31:0] rs_data_in_1;
  logic [31:0] rs_data_in_2;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        illegal;

  modport master (
    output issue_valid, ALU_Control, oprand_1, oprand_2,
    output rs_data_in_1, rs_data_in_2, rd_addr, rd_we, illegal,
    input  issue_ready
  );
  modport slave (
    input  issue_valid, ALU_Control, oprand_1, oprand_2,
    input  rs_data_in_1, rs_data_in_2, rd_addr, rd_we, illegal,
    output issue_ready
  );
endinterface

// File: rtl/alu_issue_decoder.sv
// RV32I decode/issue stage: up (instr/pc in), dn (ALU bundle out),
// rs*_addr/rs*_data regfile read, flush, issue_count handshakes.
module alu_issue_decoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  instr_if.slave           up,
  issue_if.master          dn,
  output logic [4:0]       rs1_addr,
  output logic [4:0]       rs2_addr,
  input  logic [31:0]      rs1_data,
  input  logic [31:0]      rs2_data,
  input  logic             flush,
  output logic [CNT_W-1:0] issue_count
);

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] rv1;
    logic [31:0] rv2;
    logic [4:0]  rd;
    logic        rd_we;
    logic        ill;
  } bndl_t;

  bndl_t            out_q, out_d;
  bndl_t            skid_q, skid_d;
  bndl_t            dec;
  logic             out_v_q, out_v_d;
  logic             skid_v_q, skid_v_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] rv1, rv2;
  logic [31:0] i_imm, b_imm, u_imm, shamt;
  logic        is_op, is_opi, is_lui, is_aui, is_br;
  logic        bad;
  logic        accept, hs, out_free;

  assign rs1_addr = up.instr[19:15];
  assign rs2_addr = up.instr[24:20];
  assign rv1 = (rs1_addr == 5'd0) ? 32'd0 : rs1_data;
  assign rv2 = (rs2_addr == 5'd0) ? 32'd0 : rs2_data;

  assign opc = up.instr[6:0];
  assign f3  = up.instr[14:12];
  assign f7  = up.instr[31:25];

  assign i_imm = {{20{up.instr[31]}}, up.instr[31:20]};
  assign b_imm = {{19{up.instr[31]}}, up.instr[31], up.instr[7],
                  up.instr[30:25], up.instr[11:8], 1'b0};
  assign u_imm = {up.instr[31:12], 12'b0};
  assign shamt = {27'b0, up.instr[24:20]};

  assign is_op  = (opc == 7'b0110011);
  assign is_opi = (opc == 7'b0010011);
  assign is_lui = (opc == 7'b0110111);
  assign is_aui = (opc == 7'b0010111);
  assign is_br  = (opc == 7'b1100011);

  always_comb begin
    dec       = '0;
    dec.rv1   = rv1;
    dec.rv2   = rv2;
    dec.rd    = up.instr[11:7];
    bad       = 1'b0;
    unique case (1'b1)
      is_op: begin
        dec.op1   = rv1;
        dec.op2   = rv2;
        dec.rd_we = 1'b1;
        dec.ctrl  = {1'b0, f3};
        if (f7 == 7'b0100000 && f3 == 3'b000)
          dec.ctrl = 4'b1010;
        else if (f7 == 7'b0100000 && f3 == 3'b101)
          dec.ctrl = 4'b1011;
        else if (f7 != 7'd0)
          bad = 1'b1;
      end
      is_opi: begin
        dec.op1   = rv1;
        dec.op2   = i_imm;
        dec.rd_we = 1'b1;
        dec.ctrl  = {1'b0, f3};
        if (f3 == 3'b001) begin
          dec.op2 = shamt;
          if (f7 != 7'd0) bad = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.op2 = shamt;
          if (up.instr[30])
            dec.ctrl = 4'b1011;
          else if (f7 != 7'd0)
            bad = 1'b1;
        end
      end
      is_lui: begin
        dec.op2   = u_imm;
        dec.rd_we = 1'b1;
      end
      is_aui: begin
        dec.op1   = up.pc;
        dec.op2   = u_imm;
        dec.rd_we = 1'b1;
      end
      is_br: begin
        dec.ctrl = {1'b1, f3};
        dec.op1  = up.pc;
        dec.op2  = b_imm;
        if (f3[2:1] == 2'b01) bad = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      dec.ctrl  = 4'd0;
      dec.op1   = 32'd0;
      dec.op2   = 32'd0;
      dec.rd_we = 1'b0;
      dec.ill   = 1'b1;
    end
  end

  assign up.instr_ready = ~skid_v_q;
  assign accept   = up.instr_valid & ~skid_v_q;
  assign hs       = out_v_q & dn.issue_ready;
  assign out_free = ~out_v_q | hs;

  // Skid is only ever filled while out is stalled, and accept is
  // blocked while skid holds data, so skid always drains first.
  always_comb begin
    out_d    = out_q;
    out_v_d  = out_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    cnt_d    = cnt_q;
    if (flush) begin
      out_v_d  = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      if (hs) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (out_free) begin
        if (skid_v_q) begin
          out_d    = skid_q;
          out_v_d  = 1'b1;
          skid_v_d = 1'b0;
        end else if (accept) begin
          out_d   = dec;
          out_v_d = 1'b1;
        end else begin
          out_v_d = 1'b0;
        end
      end else if (accept) begin
        skid_d   = dec;
        skid_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q    <= '0;
      out_v_q  <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      out_q    <= out_d;
      out_v_q  <= out_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dn.issue_valid  = out_v_q;
  assign dn.ALU_Control  = out_q.ctrl;
  assign dn.oprand_1     = out_q.op1;
  assign dn.oprand_2     = out_q.op2;
  assign dn.rs_data_in_1 = out_q.rv1;
  assign dn.rs_data_in_2 = out_q.rv2;
  assign dn.rd_addr      = out_q.rd;
  assign dn.rd_we        = out_q.rd_we;
  assign dn.illegal      = out_q.ill;
  assign issue_count     = cnt_q;

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Directed bench for alu_issue_decoder.
// Regfile modelled as an array, expected values hand-computed.
module tb_alu_issue_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [15:0] issue_count;
  logic [31:0] rf [32];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  instr_if u_in ();
  issue_if u_is ();

  alu_issue_decoder #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .up          (u_in.slave),
    .dn          (u_is.master),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .flush       (flush),
    .issue_count (issue_count)
  );

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    u_in.instr_valid = 1'b1;
    u_in.instr       = i;
    u_in.pc          = p;
    step();
    u_in.instr_valid = 1'b0;
  endtask

  task automatic drain();
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("drain_cnt", 32'(issue_count), 32'(exp_cnt));
    chk("drain_v", 32'(u_is.issue_valid), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + i;
    rf[0] = 32'hdeadbeef;
    rf[1] = 32'h1;
    rf[2] = 32'h4000_0001;
    rf[6] = 32'h1234_5678;
    u_in.instr_valid  = 1'b0;
    u_in.instr        = 32'd0;
    u_in.pc           = 32'd0;
    u_is.issue_ready  = 1'b1;

    step();
    step();
    chk("rst_v", 32'(u_is.issue_valid), 32'd0);
    chk("rst_rdy", 32'(u_in.instr_ready), 32'd1);
    chk("rst_cnt", 32'(issue_count), 32'd0);
    rst = 1'b1;
    step();

    // add x3,x1,x2
    u_in.instr = 32'h002081B3;
    #1;
    chk("rs1_addr", 32'(rs1_addr), 32'd1);
    chk("rs2_addr", 32'(rs2_addr), 32'd2);
    send(32'h002081B3, 32'h100);
    chk("add_v", 32'(u_is.issue_valid), 32'd1);
    chk("add_ctl", 32'(u_is.ALU_Control), 32'h0);
    chk("add_op1", u_is.oprand_1, 32'h1);
    chk("add_op2", u_is.oprand_2, 32'h4000_0001);
    chk("add_rd", 32'(u_is.rd_addr), 32'd3);
    chk("add_we", 32'(u_is.rd_we), 32'd1);
    chk("add_ill", 32'(u_is.illegal), 32'd0);
    drain();

    // add x7,x0,x1 : x0 reads as zero
    send(32'h001003B3, 32'h104);
    chk("x0_op1", u_is.oprand_1, 32'h0);
    chk("x0_rs1", u_is.rs_data_in_1, 32'h0);
    chk("x0_rs2", u_is.rs_data_in_2, 32'h1);
    drain();

    // srai x5,x6,8
    send(32'h40835293, 32'h108);
    chk("srai_ctl", 32'(u_is.ALU_Control), 32'hB);
    chk("srai_op1", u_is.oprand_1, 32'h1234_5678);
    chk("srai_op2", u_is.oprand_2, 32'd8);
    chk("srai_rd", 32'(u_is.rd_addr), 32'd5);
    drain();

    // srli x5,x6,8
    send(32'h00835293, 32'h10C);
    chk("srli_ctl", 32'(u_is.ALU_Control), 32'h5);
    chk("srli_op2", u_is.oprand_2, 32'd8);
    drain();

    // slli with funct7 bit set: illegal
    send(32'h40831293, 32'h110);
    chk("slli_ill", 32'(u_is.illegal), 32'd1);
    chk("slli_we", 32'(u_is.rd_we), 32'd0);
    chk("slli_op1", u_is.oprand_1, 32'd0);
    drain();

    // sub x3,x1,x2
    send(32'h402081B3, 32'h114);
    chk("sub_ctl", 32'(u_is.ALU_Control), 32'hA);
    chk("sub_op2", u_is.oprand_2, 32'h4000_0001);
    drain();

    // funct7 0000001 on OP: illegal
    send(32'h022081B3, 32'h118);
    chk("mul_ill", 32'(u_is.illegal), 32'd1);
    chk("mul_ctl", 32'(u_is.ALU_Control), 32'h0);
    drain();

    // addi x4,x1,-1
    send(32'hFFF08213, 32'h11C);
    chk("addi_op2", u_is.oprand_2, 32'hFFFF_FFFF);
    chk("addi_rd", 32'(u_is.rd_addr), 32'd4);
    drain();

    // beq x1,x2,+8
    send(32'h00208463, 32'h8810_4225);
    chk("beq_ctl", 32'(u_is.ALU_Control), 32'h8);
    chk("beq_op1", u_is.oprand_1, 32'h8810_4225);
    chk("beq_op2", u_is.oprand_2, 32'd8);
    chk("beq_rs1", u_is.rs_data_in_1, 32'h1);
    chk("beq_rs2", u_is.rs_data_in_2, 32'h4000_0001);
    chk("beq_we", 32'(u_is.rd_we), 32'd0);
    drain();

    // branch funct3 010: illegal
    send(32'h0020A463, 32'h200);
    chk("br010_ill", 32'(u_is.illegal), 32'd1);
    drain();

    // lui x10,0x12345 / auipc x10,0x12345
    send(32'h12345537, 32'h300);
    chk("lui_op1", u_is.oprand_1, 32'h0);
    chk("lui_op2", u_is.oprand_2, 32'h1234_5000);
    chk("lui_rd", 32'(u_is.rd_addr), 32'd10);
    drain();
    send(32'h12345517, 32'h1000);
    chk("aui_op1", u_is.oprand_1, 32'h1000);
    chk("aui_op2", u_is.oprand_2, 32'h1234_5000);
    drain();

    // Backpressure: add, sub, xor offered back to back
    u_is.issue_ready = 1'b0;
    u_in.instr_valid = 1'b1;
    u_in.instr       = 32'h002081B3;
    step();
    u_in.instr = 32'h402081B3;
    step();
    chk("bp_full_rdy", 32'(u_in.instr_ready), 32'd0);
    u_in.instr = 32'h0020C1B3;
    step();
    chk("bp_hold_ctl", 32'(u_is.ALU_Control), 32'h0);
    chk("bp_hold_rdy", 32'(u_in.instr_ready), 32'd0);
    chk("bp_hold_cnt", 32'(issue_count), 32'(exp_cnt));
    u_is.issue_ready = 1'b1;
    step();
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_b_ctl", 32'(u_is.ALU_Control), 32'hA);
    chk("bp_b_rdy", 32'(u_in.instr_ready), 32'd1);
    chk("bp_b_cnt", 32'(issue_count), 32'(exp_cnt));
    step();
    u_in.instr_valid = 1'b0;
    exp_cnt = exp_cnt + 16'd1;
    chk("bp_c_ctl", 32'(u_is.ALU_Control), 32'h4);
    chk("bp_c_cnt", 32'(issue_count), 32'(exp_cnt));
    drain();

    // Flush with both registers full; offered instr is dropped
    u_is.issue_ready = 1'b0;
    send(32'h002081B3, 32'h400);
    send(32'h402081B3, 32'h404);
    chk("fl_full_rdy", 32'(u_in.instr_ready), 32'd0);
    u_in.instr_valid = 1'b1;
    u_in.instr       = 32'h0020C1B3;
    flush            = 1'b1;
    step();
    flush            = 1'b0;
    u_in.instr_valid = 1'b0;
    chk("fl_v", 32'(u_is.issue_valid), 32'd0);
    chk("fl_rdy", 32'(u_in.instr_ready), 32'd1);
    chk("fl_cnt", 32'(issue_count), 32'(exp_cnt));
    u_is.issue_ready = 1'b1;
    step();
    chk("fl_drop", 32'(u_is.issue_valid), 32'd0);

    // load opcode: illegal
    send(32'h00000003, 32'h500);
    chk("ld_v", 32'(u_is.issue_valid), 32'd1);
    chk("ld_ill", 32'(u_is.illegal), 32'd1);
    chk("ld_we", 32'(u_is.rd_we), 32'd0);
    drain();

    // Reset mid-stream with skid full
    u_is.issue_ready = 1'b0;
    send(32'h002081B3, 32'h600);
    send(32'h402081B3, 32'h604);
    rst = 1'b0;
    #1;
    chk("mr_v", 32'(u_is.issue_valid), 32'd0);
    chk("mr_rdy", 32'(u_in.instr_ready), 32'd1);
    chk("mr_cnt", 32'(issue_count), 32'd0);
    step();
    step();
    chk("mr_op1", u_is.oprand_1, 32'd0);
    chk("mr_op2", u_is.oprand_2, 32'd0);
    chk("mr_rs1", u_is.rs_data_in_1, 32'd0);
    chk("mr_rd", 32'(u_is.rd_addr), 32'd0);
    chk("mr_we", 32'(u_is.rd_we), 32'd0);
    rst = 1'b1;
    exp_cnt = 16'd0;
    u_is.issue_ready = 1'b1;
    step();
    send(32'h00835293, 32'h700);
    chk("post_ctl", 32'(u_is.ALU_Control), 32'h5);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
